lsu_ram_ctrl: RTL and testbench

- Data-RAM controller directly downstream of the load/store unit's RAM port.
- Accepts word-addressed read/write commands (valid/rd/wr/addr/wdata) and owns a DEPTH-word synchronous storage array.
- Returns rdata plus a one-cycle ready pulse after a programmable number of wait states.
- Read data is held stable through the following write, so the LSU's read-modify-write merge for sub-word stores sees the pre-write word.

---
 rtl/lsu_ram_ctrl.sv | 133 +++++++++++++
 tb/tb_lsu_ram_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_ctrl.sv
// lsu_ram_ctrl: data-RAM controller that sits directly behind the load/store
// unit's RAM port. It owns a DEPTH x 32-bit synchronous array. Each command is
// latched in IDLE, completes after WAIT_CYCLES extra wait states, and is
// answered with a one-cycle ready pulse.
//
// Handshake: the requester raises lsu_ram_valid with wr/rd/addr/wdata and holds
// them until it sees ram_lsu_ready. The command is latched on the edge that
// leaves IDLE. After that, input changes are ignored. ram_lsu_ready is high for
// exactly one cycle (RESP) per accepted command. RESP always returns to IDLE.
// A valid that is still high in IDLE after RESP is taken as the next command,
// so the throughput is one command per WAIT_CYCLES+3 cycles.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   lsu_ram_valid  command valid
//   lsu_ram_wr     write command (wins when rd is also set)
//   lsu_ram_rd     read command
//   lsu_ram_addr   word index (AW bits); addr >= DEPTH is out of range
//   lsu_ram_wdata  full merged write word
//   ram_lsu_rdata  registered read data, held until the next completed read
//   ram_lsu_ready  one-cycle completion pulse
//   ram_lsu_err    exists only when the macro LSU_RAM_ERR_EN is defined. It
//                  flags an out-of-range access together with ready.
//
// The FSM state is held in the enum variable 'state' (IDLE/BUSY/RESP), so it
// can be observed directly.
module lsu_ram_ctrl #(
  parameter int DEPTH       = 4096,
  parameter int AW          = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_ram_valid,
  input  logic          lsu_ram_wr,
  input  logic          lsu_ram_rd,
  input  logic [AW-1:0] lsu_ram_addr,
  input  logic [31:0]   lsu_ram_wdata,
  output logic [31:0]   ram_lsu_rdata,
  output logic          ram_lsu_ready
`ifdef LSU_RAM_ERR_EN
  ,
  output logic          ram_lsu_err
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          wr_q;
  logic          rd_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  logic          in_range;
  logic          access;
  logic [IW-1:0] idx;

  // The range check uses the full latched address, so an out-of-range index
  // never wraps onto a real word.
  assign in_range = (addr_q < AW'(DEPTH));
  assign access   = (state == BUSY) && (cnt == 4'd0);
  assign idx      = addr_q[IW-1:0];

  // Storage has no reset. A write whose access edge coincides with rst is
  // suppressed.
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'h0;
      ram_lsu_rdata <= 32'h0;
      ram_lsu_ready <= 1'b0;
`ifdef LSU_RAM_ERR_EN
      ram_lsu_err   <= 1'b0;
`endif
    end else begin
      ram_lsu_ready <= 1'b0;
`ifdef LSU_RAM_ERR_EN
      ram_lsu_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (lsu_ram_valid) begin
            wr_q    <= lsu_ram_wr;
            rd_q    <= lsu_ram_rd;
            addr_q  <= lsu_ram_addr;
            wdata_q <= lsu_ram_wdata;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // A write leaves rdata untouched. The LSU merge logic relies on
            // rdata still holding the pre-write word.
            if (!wr_q && rd_q) begin
              ram_lsu_rdata <= in_range ? mem[idx] : 32'h0;
            end
            ram_lsu_ready <= 1'b1;
`ifdef LSU_RAM_ERR_EN
            ram_lsu_err   <= ~in_range;
`endif
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Directed bench for lsu_ram_ctrl. It runs three instances that share clk and
// rst, all with DEPTH = 16:
//   u0: WAIT_CYCLES = 0
//   u1: WAIT_CYCLES = 3
//   u2: WAIT_CYCLES = 2
// Every expected value below is worked out by hand from the controller's
// behaviour.
module tb_lsu_ram_ctrl;

  logic        clk;
  logic        rst;
  logic        valid_s [3];
  logic        wr_s    [3];
  logic        rd_s    [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        ready_s [3];
  logic        err_s   [3];

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs ----------------
  lsu_ram_ctrl #(.DEPTH(16), .AW(32), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst),
    .lsu_ram_valid(valid_s[0]), .lsu_ram_wr(wr_s[0]), .lsu_ram_rd(rd_s[0]),
    .lsu_ram_addr(addr_s[0]), .lsu_ram_wdata(wdata_s[0]),
    .ram_lsu_rdata(rdata_s[0]), .ram_lsu_ready(ready_s[0])
`ifdef LSU_RAM_ERR_EN
    , .ram_lsu_err(err_s[0])
`endif
  );

  lsu_ram_ctrl #(.DEPTH(16), .AW(32), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst),
    .lsu_ram_valid(valid_s[1]), .lsu_ram_wr(wr_s[1]), .lsu_ram_rd(rd_s[1]),
    .lsu_ram_addr(addr_s[1]), .lsu_ram_wdata(wdata_s[1]),
    .ram_lsu_rdata(rdata_s[1]), .ram_lsu_ready(ready_s[1])
`ifdef LSU_RAM_ERR_EN
    , .ram_lsu_err(err_s[1])
`endif
  );

  lsu_ram_ctrl #(.DEPTH(16), .AW(32), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst),
    .lsu_ram_valid(valid_s[2]), .lsu_ram_wr(wr_s[2]), .lsu_ram_rd(rd_s[2]),
    .lsu_ram_addr(addr_s[2]), .lsu_ram_wdata(wdata_s[2]),
    .ram_lsu_rdata(rdata_s[2]), .ram_lsu_ready(ready_s[2])
`ifdef LSU_RAM_ERR_EN
    , .ram_lsu_err(err_s[2])
`endif
  );

`ifndef LSU_RAM_ERR_EN
  initial begin
    for (int i = 0; i < 3; i++) err_s[i] = 1'b0;
  end
`endif

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the instance idle. The bench holds valid until it
  // sees ready. The address switches to a2 one cycle after the accept. The
  // latency is counted in cycles from the accept edge to the cycle where ready
  // is first seen.
  task automatic run_cmd(input int u, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] a2,
                         input logic [31:0] d, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input string tag);
    int k;
    logic seen;
    valid_s[u] = 1'b1;
    wr_s[u]    = w;
    rd_s[u]    = r;
    addr_s[u]  = a;
    wdata_s[u] = d;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        addr_s[u]  = a2;
        wdata_s[u] = ~d;
      end
      if (ready_s[u]) seen = 1'b1;
    end
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_rdata"}, rdata_s[u], exp_rdata);
`ifdef LSU_RAM_ERR_EN
    check({tag, "_err"}, {31'h0, err_s[u]}, {31'h0, exp_err});
`endif
    valid_s[u] = 1'b0;
    wr_s[u]    = 1'b0;
    rd_s[u]    = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {31'h0, ready_s[u]}, 32'h0);
`ifdef LSU_RAM_ERR_EN
    check({tag, "_err_off"}, {31'h0, err_s[u]}, 32'h0);
`endif
  endtask

  // Starts a write, then pulses rst at the negedge after the accept edge.
  task automatic aborted_write(input int u, input logic [31:0] a, input logic [31:0] d,
                               input string tag);
    valid_s[u] = 1'b1;
    wr_s[u]    = 1'b1;
    rd_s[u]    = 1'b0;
    addr_s[u]  = a;
    wdata_s[u] = d;
    @(negedge clk);
    rst        = 1'b1;
    valid_s[u] = 1'b0;
    wr_s[u]    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_rdata0"}, rdata_s[u], 32'h0);
    for (int i = 0; i < 6; i++) begin
      check({tag, "_noready"}, {31'h0, ready_s[u]}, 32'h0);
      @(negedge clk);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_s[i] = 1'b0;
      wr_s[i]    = 1'b0;
      rd_s[i]    = 1'b0;
      addr_s[i]  = 32'h0;
      wdata_s[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing moves.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("idle_ready", {31'h0, ready_s[i]}, 32'h0);
        check("idle_rdata", rdata_s[i], 32'h0);
      end
    end

    // WAIT_CYCLES = 0: write, then read back.
    run_cmd(0, 1, 0, 5, 5, 32'hDEADBEEF, 2, 32'h0, 0, "wr5");
    run_cmd(0, 0, 1, 5, 5, 32'h0, 2, 32'hDEADBEEF, 0, "rd5");
    check("rd5_hold", rdata_s[0], 32'hDEADBEEF);

    // Read-modify-write: rdata keeps the pre-write word.
    run_cmd(0, 1, 0, 3, 3, 32'h11223344, 2, 32'hDEADBEEF, 0, "pre3");
    run_cmd(0, 0, 1, 3, 3, 32'h0, 2, 32'h11223344, 0, "rmw_rd");
    run_cmd(0, 1, 0, 3, 3, 32'h112233AA, 2, 32'h11223344, 0, "rmw_wr");
    check("rmw_hold", rdata_s[0], 32'h11223344);
    run_cmd(0, 0, 1, 3, 3, 32'h0, 2, 32'h112233AA, 0, "rmw_rd2");

    // wr and rd both set acts as a write; no-op command still pulses ready.
    run_cmd(0, 1, 1, 4, 4, 32'hCAFEF00D, 2, 32'h112233AA, 0, "wrrd4");
    run_cmd(0, 0, 1, 4, 4, 32'h0, 2, 32'hCAFEF00D, 0, "rd4");
    run_cmd(0, 0, 0, 9, 9, 32'h0, 2, 32'hCAFEF00D, 0, "nop");

    // WAIT_CYCLES = 3: address changes after accept are ignored.
    run_cmd(1, 1, 0, 7, 7, 32'h77777777, 5, 32'h0, 0, "w3_wr7");
    run_cmd(1, 1, 0, 9, 9, 32'h99999999, 5, 32'h0, 0, "w3_wr9");
    run_cmd(1, 0, 1, 7, 9, 32'h0, 5, 32'h77777777, 0, "w3_rd7");

    // Out of range with DEPTH = 16: no wrap onto word 0.
    run_cmd(0, 1, 0, 0, 0, 32'h00000A0A, 2, 32'hCAFEF00D, 0, "pre0");
    run_cmd(0, 1, 0, 16, 16, 32'hFFFFFFFF, 2, 32'hCAFEF00D, 1, "oor_wr");
    run_cmd(0, 0, 1, 16, 16, 32'h0, 2, 32'h0, 1, "oor_rd");
    run_cmd(0, 0, 1, 0, 0, 32'h0, 2, 32'h00000A0A, 0, "rd0");
    run_cmd(0, 0, 1, 32'h80000000, 32'h80000000, 32'h0, 2, 32'h0, 1, "oor_big");

    // Reset during BUSY of a WAIT_CYCLES = 2 write.
    run_cmd(2, 1, 0, 2, 2, 32'h0000AAAA, 4, 32'h0, 0, "w2_pre2");
    aborted_write(2, 2, 32'h00005555, "w2_abort");
    run_cmd(2, 0, 1, 2, 2, 32'h0, 4, 32'h0000AAAA, 0, "w2_rd2");

    // Reset on the very edge where a WAIT_CYCLES = 0 write would land.
    run_cmd(0, 1, 0, 6, 6, 32'h00000066, 2, 32'h0, 0, "w0_pre6");
    aborted_write(0, 6, 32'h00000077, "w0_abort");
    run_cmd(0, 0, 1, 6, 6, 32'h0, 2, 32'h00000066, 0, "w0_rd6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
